// File: rtl/riscv_pkg.sv
// Shared definitions for the decode->execute boundary.
// Holds the datapath/register-index widths, the ALU operation and
// forwarding-select encodings, the E-stage register bundle, and the
// forwarding-select helper used by forward_unit.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    // Everything the E stage latches from D. An all-zero value is the bubble:
    // not valid, no write, ALU op ADD, all indices x0.
    typedef struct packed {
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        alu_op_e           alu_control;
        logic              alu_src;
        logic              reg_write;
        logic              valid;
    } ex_regs_t;

    // The younger producer (M) wins over the older one (W); x0 is hardwired
    // to zero, so a write to it must never be forwarded.
    function automatic fwd_sel_e fwd_select(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w
    );
        if (we_m && (rd_m != '0) && (rd_m == rs))
            return FWD_M;
        else if (we_w && (rd_w != '0) && (rd_w == rs))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of every signal crossing the ID/EX stage boundary.
//   master : decode side / hazard unit / later stages (drives D-stage data,
//            StallE/FlushE and the M/W forwarding sources, reads E outputs)
//   slave  : the id_ex_stage register itself
interface id_ex_stage_if
    import riscv_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic              StallE;
    logic              FlushE;
    logic              ValidD;
    logic [XLEN-1:0]   RD1D;
    logic [XLEN-1:0]   RD2D;
    logic [XLEN-1:0]   ImmExtD;
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [REG_AW-1:0] RdD;
    alu_op_e           ALUControlD;
    logic              ALUSrcD;
    logic              RegWriteD;

    logic [XLEN-1:0]   ALUResultM;
    logic [REG_AW-1:0] RdM;
    logic              RegWriteM;
    logic [XLEN-1:0]   ResultW;
    logic [REG_AW-1:0] RdW;
    logic              RegWriteW;

    logic [XLEN-1:0]   SrcAE;
    logic [XLEN-1:0]   SrcBE;
    logic [XLEN-1:0]   WriteDataE;
    alu_op_e           ALUControlE;
    logic [REG_AW-1:0] RdE;
    logic [REG_AW-1:0] Rs1E;
    logic [REG_AW-1:0] Rs2E;
    logic              RegWriteE;
    logic              ValidE;
    logic [CNT_W-1:0]  BubbleCnt;

    modport master (
        output StallE, FlushE, ValidD, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
               ALUControlD, ALUSrcD, RegWriteD,
               ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW,
        input  SrcAE, SrcBE, WriteDataE, ALUControlE, RdE, Rs1E, Rs2E,
               RegWriteE, ValidE, BubbleCnt
    );

    modport slave (
        input  StallE, FlushE, ValidD, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
               ALUControlD, ALUSrcD, RegWriteD,
               ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW,
        output SrcAE, SrcBE, WriteDataE, ALUControlE, RdE, Rs1E, Rs2E,
               RegWriteE, ValidE, BubbleCnt
    );

endinterface

// File: rtl/forward_unit.sv
// Combinational forwarding-select logic for both ALU source operands.
//   Rs1E, Rs2E           : registered source indices of the E-stage instruction
//   RdM, RegWriteM       : EX/MEM destination and write enable
//   RdW, RegWriteW       : MEM/WB destination and write enable
//   ForwardA, ForwardB   : operand source selects (RF, W or M)
module forward_unit
    import riscv_pkg::*;
(
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdM,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteW,
    output fwd_sel_e          ForwardA,
    output fwd_sel_e          ForwardB
);

    always_comb begin
        ForwardA = fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        ForwardB = fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register feeding the ALU.
//   clk, reset : clock and synchronous active-high reset
//   bus        : id_ex_stage_if slave port carrying D-stage inputs, hazard
//                controls (StallE/FlushE), M/W forwarding sources and the
//                forwarded E-stage outputs plus the bubble counter
// Parameter CNT_W sets the width of the saturating bubble counter.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);

    ex_regs_t         ex_q;
    ex_regs_t         ex_d;
    logic [CNT_W-1:0] bubble_cnt;
    fwd_sel_e         forward_a;
    fwd_sel_e         forward_b;
    logic [XLEN-1:0]  src_a;
    logic [XLEN-1:0]  write_data;

    always_comb begin
        ex_d             = '0;
        ex_d.rd1         = bus.RD1D;
        ex_d.rd2         = bus.RD2D;
        ex_d.imm         = bus.ImmExtD;
        ex_d.rs1         = bus.Rs1D;
        ex_d.rs2         = bus.Rs2D;
        ex_d.rd          = bus.RdD;
        ex_d.alu_control = bus.ALUControlD;
        ex_d.alu_src     = bus.ALUSrcD;
        ex_d.reg_write   = bus.RegWriteD;
        ex_d.valid       = bus.ValidD;
    end

    // A flush overrides a simultaneous stall: the hazard unit flushes when the
    // instruction in D must not reach E at all, so holding it would be wrong.
    // The counter only moves on flushes and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q       <= '0;
            bubble_cnt <= '0;
        end else if (bus.FlushE) begin
            ex_q <= '0;
            if (bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 1'b1;
        end else if (!bus.StallE) begin
            ex_q <= ex_d;
        end
    end

    forward_unit u_forward_unit (
        .Rs1E      (ex_q.rs1),
        .Rs2E      (ex_q.rs2),
        .RdM       (bus.RdM),
        .RegWriteM (bus.RegWriteM),
        .RdW       (bus.RdW),
        .RegWriteW (bus.RegWriteW),
        .ForwardA  (forward_a),
        .ForwardB  (forward_b)
    );

    // Forwarding muxes read live M/W values even while stalled, so a producer
    // that moves down the pipe during a stall is still picked up.
    always_comb begin
        case (forward_a)
            FWD_M:   src_a = bus.ALUResultM;
            FWD_W:   src_a = bus.ResultW;
            default: src_a = ex_q.rd1;
        endcase
        case (forward_b)
            FWD_M:   write_data = bus.ALUResultM;
            FWD_W:   write_data = bus.ResultW;
            default: write_data = ex_q.rd2;
        endcase
    end

    assign bus.SrcAE       = src_a;
    assign bus.WriteDataE  = write_data;
    assign bus.SrcBE       = ex_q.alu_src ? ex_q.imm : write_data;
    assign bus.ALUControlE = ex_q.alu_control;
    assign bus.RdE         = ex_q.rd;
    assign bus.Rs1E        = ex_q.rs1;
    assign bus.Rs2E        = ex_q.rs2;
    assign bus.RegWriteE   = ex_q.reg_write;
    assign bus.ValidE      = ex_q.valid;
    assign bus.BubbleCnt   = bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: load/latency, forwarding priority,
// x0 suppression, immediate select, stall, flush-over-stall, reset and
// saturation of a 4-bit bubble counter.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic clk;
    logic reset;
    int   vectorCount;
    int   missCount;

    id_ex_stage_if #(.CNT_W(4)) bus ();

    id_ex_stage #(.CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge, away from it.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic loadD(input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input alu_op_e op, input logic aluSrc,
                         input logic regWrite, input logic valid);
        bus.RD1D        = rd1;
        bus.RD2D        = rd2;
        bus.ImmExtD     = imm;
        bus.Rs1D        = rs1;
        bus.Rs2D        = rs2;
        bus.RdD         = rd;
        bus.ALUControlD = op;
        bus.ALUSrcD     = aluSrc;
        bus.RegWriteD   = regWrite;
        bus.ValidD      = valid;
    endtask

    task automatic setMW(input logic [31:0] resM, input logic [4:0] rdM, input logic weM,
                         input logic [31:0] resW, input logic [4:0] rdW, input logic weW);
        bus.ALUResultM = resM;
        bus.RdM        = rdM;
        bus.RegWriteM  = weM;
        bus.ResultW    = resW;
        bus.RdW        = rdW;
        bus.RegWriteW  = weW;
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;
        reset       = 1'b1;
        bus.StallE  = 1'b0;
        bus.FlushE  = 1'b0;
        loadD(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, ADD, 1'b0, 1'b0, 1'b0);
        setMW(32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0);
        applyStimulus(2);
        reset = 1'b0;

        checkOutput("rst_valid", 32'(bus.ValidE), 32'd0);
        checkOutput("rst_regwrite", 32'(bus.RegWriteE), 32'd0);
        checkOutput("rst_aluctl", 32'(bus.ALUControlE), 32'd0);
        checkOutput("rst_rd", 32'(bus.RdE), 32'd0);
        checkOutput("rst_bubble", 32'(bus.BubbleCnt), 32'd0);
        checkOutput("rst_srca", bus.SrcAE, 32'd0);

        // Plain load, one-cycle latency
        loadD(32'd5, 32'd7, 32'h10, 5'd3, 5'd4, 5'd6, ADD, 1'b0, 1'b1, 1'b1);
        checkOutput("pre_load_valid", 32'(bus.ValidE), 32'd0);
        applyStimulus(1);
        checkOutput("load_srca", bus.SrcAE, 32'd5);
        checkOutput("load_srcb", bus.SrcBE, 32'd7);
        checkOutput("load_wdata", bus.WriteDataE, 32'd7);
        checkOutput("load_valid", 32'(bus.ValidE), 32'd1);
        checkOutput("load_regwrite", 32'(bus.RegWriteE), 32'd1);
        checkOutput("load_rd", 32'(bus.RdE), 32'd6);
        checkOutput("load_rs2", 32'(bus.Rs2E), 32'd4);

        // M beats W; W used when M drops; operand B forwards independently
        setMW(32'h100, 5'd3, 1'b1, 32'h200, 5'd3, 1'b1);
        #1;
        checkOutput("fwd_m_over_w", bus.SrcAE, 32'h100);
        bus.RegWriteM = 1'b0;
        #1;
        checkOutput("fwd_w", bus.SrcAE, 32'h200);
        bus.RdW = 5'd4;
        #1;
        checkOutput("fwd_w_a_off", bus.SrcAE, 32'd5);
        checkOutput("fwd_w_srcb", bus.SrcBE, 32'h200);
        checkOutput("fwd_w_wdata", bus.WriteDataE, 32'h200);
        setMW(32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0);

        // x0 never forwarded; immediate selected for SrcB
        loadD(32'h33, 32'h44, 32'h10, 5'd0, 5'd5, 5'd7, SUB, 1'b1, 1'b1, 1'b1);
        applyStimulus(1);
        setMW(32'hFFFF, 5'd0, 1'b1, 32'h0, 5'd0, 1'b0);
        #1;
        checkOutput("x0_srca", bus.SrcAE, 32'h33);
        checkOutput("imm_srcb", bus.SrcBE, 32'h10);
        checkOutput("imm_wdata", bus.WriteDataE, 32'h44);
        checkOutput("sub_aluctl", 32'(bus.ALUControlE), 32'd1);

        // Stall holds registers for 3 cycles while D changes
        bus.StallE = 1'b1;
        loadD(32'h99, 32'h98, 32'h97, 5'd9, 5'd9, 5'd9, AND, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1);
            checkOutput("stall_srca", bus.SrcAE, 32'h33);
            checkOutput("stall_rd", 32'(bus.RdE), 32'd7);
            checkOutput("stall_aluctl", 32'(bus.ALUControlE), 32'd1);
            checkOutput("stall_valid", 32'(bus.ValidE), 32'd1);
        end
        // Forwarding stays live during the stall
        setMW(32'hABC, 5'd5, 1'b1, 32'h0, 5'd0, 1'b0);
        #1;
        checkOutput("stall_fwd_wdata", bus.WriteDataE, 32'hABC);
        checkOutput("stall_fwd_srcb", bus.SrcBE, 32'h10);

        // Flush with stall: bubble wins
        bus.FlushE = 1'b1;
        applyStimulus(1);
        checkOutput("flush_valid", 32'(bus.ValidE), 32'd0);
        checkOutput("flush_regwrite", 32'(bus.RegWriteE), 32'd0);
        checkOutput("flush_rd", 32'(bus.RdE), 32'd0);
        checkOutput("flush_aluctl", 32'(bus.ALUControlE), 32'd0);
        checkOutput("flush_bubble", 32'(bus.BubbleCnt), 32'd1);
        checkOutput("bubble_nofwd", bus.WriteDataE, 32'd0);
        bus.FlushE = 1'b0;
        applyStimulus(1);
        checkOutput("stall_bubble_hold", 32'(bus.BubbleCnt), 32'd1);
        setMW(32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0);

        // Reset clears a live instruction and the counter
        bus.StallE = 1'b0;
        loadD(32'h55, 32'h66, 32'h0, 5'd1, 5'd2, 5'd8, OR, 1'b0, 1'b1, 1'b1);
        applyStimulus(1);
        checkOutput("pre_rst_valid", 32'(bus.ValidE), 32'd1);
        checkOutput("or_aluctl", 32'(bus.ALUControlE), 32'd3);
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        checkOutput("rst2_valid", 32'(bus.ValidE), 32'd0);
        checkOutput("rst2_regwrite", 32'(bus.RegWriteE), 32'd0);
        checkOutput("rst2_rd", 32'(bus.RdE), 32'd0);
        checkOutput("rst2_srca", bus.SrcAE, 32'd0);
        checkOutput("rst2_bubble", 32'(bus.BubbleCnt), 32'd0);

        // Saturation of the 4-bit counter
        bus.FlushE = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            applyStimulus(1);
            if (c == 3 || c == 14 || c >= 15)
                checkOutput("sat_bubble", 32'(bus.BubbleCnt), (c >= 15) ? 32'd15 : 32'(c));
        end
        bus.FlushE = 1'b0;
        applyStimulus(1);
        checkOutput("post_sat_bubble", 32'(bus.BubbleCnt), 32'd15);
        checkOutput("post_sat_valid", 32'(bus.ValidE), 32'd1);
        checkOutput("post_sat_srca", bus.SrcAE, 32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
